// File: rtl/fp32_mul_normround_if.sv
// Beat-level bundle between the FP32 mantissa multiplier and its normalise/round/pack stage.
// Optional FP32_MUL_FLAGS_EN adds the IEEE exception flags alongside the result.
interface fp32_mul_normround_if #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 10
);
    logic                      valid_i;
    logic [2*MAN_W-1:0]        product_i;
    logic signed [EXP_W-1:0]   exp_sum_i;
    logic                      sign_i;
    logic                      nan_i;
    logic                      inf_i;
    logic                      zero_i;
    logic                      valid_o;
    logic [31:0]               result_o;
`ifdef FP32_MUL_FLAGS_EN
    logic [3:0]                flags_o;

    modport master (
        output valid_i, product_i, exp_sum_i, sign_i, nan_i, inf_i, zero_i,
        input  valid_o, result_o, flags_o
    );
    modport slave (
        input  valid_i, product_i, exp_sum_i, sign_i, nan_i, inf_i, zero_i,
        output valid_o, result_o, flags_o
    );
`else
    modport master (
        output valid_i, product_i, exp_sum_i, sign_i, nan_i, inf_i, zero_i,
        input  valid_o, result_o
    );
    modport slave (
        input  valid_i, product_i, exp_sum_i, sign_i, nan_i, inf_i, zero_i,
        output valid_o, result_o
    );
`endif
endinterface

// File: rtl/fp32_mul_normround.sv
// FP32 multiply back end: normalise, round-to-nearest-even, exceptions/FTZ, pack; 3-cycle latency.
// Define FP32_MUL_FLAGS_EN to also produce {invalid, overflow, underflow, inexact} flags.
module fp32_mul_normround #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fp32_mul_normround_if.slave  bus
);
    localparam int PW     = 2 * MAN_W;
    localparam int STAGES = 3;
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } spec_t;

    logic [STAGES:1] vld_pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_pipe_q <= '0;
        else       vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.valid_i};
    end

    assign bus.valid_o = vld_pipe_q[STAGES];

    // ---------------- stage 1: normalise ----------------
    logic [MAN_W-1:0]        man1_d, man1_q;
    logic                    g1_d, g1_q, s1_d, s1_q;
    logic signed [EXP_W-1:0] exp1_d, exp1_q;
    spec_t                   spec1_q;

    always_comb begin
        man1_d = bus.product_i[PW-2 -: MAN_W];
        g1_d   = bus.product_i[MAN_W-2];
        s1_d   = |bus.product_i[MAN_W-3:0];
        exp1_d = bus.exp_sum_i;
        if (bus.product_i[PW-1]) begin
            man1_d = bus.product_i[PW-1 -: MAN_W];
            g1_d   = bus.product_i[MAN_W-1];
            s1_d   = |bus.product_i[MAN_W-2:0];
            exp1_d = bus.exp_sum_i + EXP_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            man1_q  <= '0;
            g1_q    <= 1'b0;
            s1_q    <= 1'b0;
            exp1_q  <= '0;
            spec1_q <= '0;
        end else if (bus.valid_i) begin
            man1_q  <= man1_d;
            g1_q    <= g1_d;
            s1_q    <= s1_d;
            exp1_q  <= exp1_d;
            spec1_q <= '{sign: bus.sign_i, nan: bus.nan_i, inf: bus.inf_i, zero: bus.zero_i};
        end
    end

    // ---------------- stage 2: round to nearest even ----------------
    logic                    inc;
    logic [MAN_W:0]          man_sum;
    logic [MAN_W-1:0]        man2_d, man2_q;
    logic signed [EXP_W-1:0] exp2_d, exp2_q;
    logic                    inexact2_q;
    spec_t                   spec2_q;

    always_comb begin
        inc     = g1_q & (s1_q | man1_q[0]);
        man_sum = {1'b0, man1_q} + {{MAN_W{1'b0}}, inc};
        man2_d  = man_sum[MAN_W-1:0];
        exp2_d  = exp1_q;
        // Rounding 1.111..1 up lands on 2.0: renormalise to 1.0 and bump the exponent.
        if (man_sum[MAN_W]) begin
            man2_d = {1'b1, {(MAN_W-1){1'b0}}};
            exp2_d = exp1_q + EXP_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            man2_q     <= '0;
            exp2_q     <= '0;
            inexact2_q <= 1'b0;
            spec2_q    <= '0;
        end else if (vld_pipe_q[1]) begin
            man2_q     <= man2_d;
            exp2_q     <= exp2_d;
            inexact2_q <= g1_q | s1_q;
            spec2_q    <= spec1_q;
        end
    end

    // The hidden bit is implied in the packed format.
    logic unused_hidden;
    assign unused_hidden = man2_q[MAN_W-1];

    // ---------------- stage 3: exceptions and pack ----------------
    logic        ovf, unf;
    logic [31:0] result_d, result_q;
    logic [3:0]  flags_d;

    assign ovf = (exp2_q >= EXP_MAX);
    assign unf = (exp2_q <= EXP_ZERO);

    always_comb begin
        result_d = {spec2_q.sign, exp2_q[7:0], man2_q[MAN_W-2:0]};
        flags_d  = {3'b000, inexact2_q};
        if (spec2_q.nan) begin
            result_d = 32'h7FC0_0000;
            flags_d  = 4'b1000;
        end else if (spec2_q.inf) begin
            result_d = {spec2_q.sign, 8'hFF, 23'h0};
            flags_d  = 4'b0000;
        end else if (spec2_q.zero) begin
            result_d = {spec2_q.sign, 31'h0};
            flags_d  = 4'b0000;
        end else if (ovf) begin
            result_d = {spec2_q.sign, 8'hFF, 23'h0};
            flags_d  = 4'b0101;
        end else if (unf) begin
            result_d = {spec2_q.sign, 31'h0};
            flags_d  = 4'b0011;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)               result_q <= '0;
        else if (vld_pipe_q[2])  result_q <= result_d;
    end

    assign bus.result_o = result_q;

`ifdef FP32_MUL_FLAGS_EN
    logic [3:0] flags_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)               flags_q <= '0;
        else if (vld_pipe_q[2])  flags_q <= flags_d;
    end

    assign bus.flags_o = flags_q;
`else
    logic [3:0] unused_flags;
    assign unused_flags = flags_d;
`endif
endmodule

// File: tb/tb_fp32_mul_normround.sv
// Directed bench for fp32_mul_normround: latency, rounding, exceptions, throughput, reset flush.
module tb_fp32_mul_normround;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp32_mul_normround_if bus ();

    fp32_mul_normround dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [47:0] p, input int e, input logic s,
                         input logic n, input logic i, input logic z);
        bus.valid_i   = 1'b1;
        bus.product_i = p;
        bus.exp_sum_i = 10'(e);
        bus.sign_i    = s;
        bus.nan_i     = n;
        bus.inf_i     = i;
        bus.zero_i    = z;
    endtask

    task automatic idle();
        bus.valid_i   = 1'b0;
        bus.product_i = '0;
        bus.exp_sum_i = '0;
        bus.sign_i    = 1'b0;
        bus.nan_i     = 1'b0;
        bus.inf_i     = 1'b0;
        bus.zero_i    = 1'b0;
    endtask

    // One isolated beat: valid_o must be low for two cycles, high on the third, then hold.
    task automatic run_one(input string tag, input logic [47:0] p, input int e, input logic s,
                           input logic n, input logic i, input logic z,
                           input logic [31:0] exp_res, input logic [3:0] exp_fl);
        @(negedge clk); drive(p, e, s, n, i, z);
        @(negedge clk); idle(); chk({tag, "_lat1"}, 32'(bus.valid_o), 32'd0);
        @(negedge clk); chk({tag, "_lat2"}, 32'(bus.valid_o), 32'd0);
        @(negedge clk); chk({tag, "_vld"}, 32'(bus.valid_o), 32'd1);
        chk(tag, bus.result_o, exp_res);
`ifdef FP32_MUL_FLAGS_EN
        chk({tag, "_flags"}, 32'(bus.flags_o), 32'(exp_fl));
`else
        if (exp_fl === 4'hx) $display("note: unused flag expectation");
`endif
        @(negedge clk); chk({tag, "_hold"}, bus.result_o, exp_res);
        chk({tag, "_vdrop"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'h0);
        rst = 1'b0;

        run_one("norm_1p0",  48'h4000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0000);
        run_one("norm_msb",  48'h9000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 4'b0000);
        run_one("rne_up",    48'h4000_00C0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 4'b0001);
        run_one("rne_even",  48'h4000_0040_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001);
        run_one("rnd_carry", 48'h7FFF_FFC0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4'b0001);
        run_one("overflow",  48'h8000_0000_0000, 254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 4'b0101);
        run_one("underflow", 48'h4000_0000_0000, 0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0011);
        run_one("nan",       48'h4000_0000_0000, 127, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FC0_0000, 4'b1000);
        run_one("inf_neg",   48'h4000_0000_0000, 127, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 4'b0000);
        run_one("zero",      48'h4000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 4'b0000);
        run_one("nan_inf",   48'h4000_0000_0000, 127, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 4'b1000);
        run_one("max_norm",  48'h4000_0000_0000, 254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 4'b0000);

        // Eight back-to-back beats; results stream out three cycles behind.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                chk($sformatf("tput_vld%0d", c - 3), 32'(bus.valid_o), 32'd1);
                chk($sformatf("tput_res%0d", c - 3), bus.result_o, 32'((120 + c - 3) << 23));
            end
            if (c < 8) drive(48'h4000_0000_0000, 120 + c, 1'b0, 1'b0, 1'b0, 1'b0);
            else       idle();
        end
        @(negedge clk);
        chk("tput_end", 32'(bus.valid_o), 32'd0);

        // Reset with two beats in flight: neither may emerge.
        @(negedge clk); drive(48'h4000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(48'h9000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush_vld%0d", c), 32'(bus.valid_o), 32'd0);
            chk($sformatf("flush_res%0d", c), bus.result_o, 32'h0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_mul_normround.md
Name: fp32_mul_normround

Overview:
- Pipelined post-multiply stage of the FP32 multiplier.
- Sits directly downstream of the 24x24 unsigned Karatsuba mantissa multiplier and consumes its 48-bit product.
- Also takes the sign, the pre-normalisation exponent and the special-case flags, delay-matched by the parent.
- Normalises, rounds to nearest-even, handles exceptions and flush-to-zero, and packs the IEEE-754 single-precision result. Fixed 3-cycle latency, one result per cycle.

Parameters:
- MAN_W, 24, significand width including hidden bit; product width is 2*MAN_W.
- EXP_W, 10, signed two's-complement width of the internal exponent path.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input beat valid; no backpressure.
- product_i  in  48  unsigned mantissa product (1.xx * 1.xx, range [2^46, 2^48)).
- exp_sum_i  in  10  signed biased exponent ea+eb-127, before normalisation.
- sign_i  in  1  sa XOR sb.
- nan_i  in  1  result is NaN (NaN operand, or inf*0).
- inf_i  in  1  result is infinity.
- zero_i  in  1  result is zero (zero or subnormal operand; FTZ upstream).
- valid_o  out  1  result valid.
- result_o  out  32  packed FP32 result.

Behaviour:
- Reset: all pipeline registers cleared; valid_o=0, result_o=32'h0 on the cycle after rst_i is sampled high.
- Reset asserted mid-operation discards all in-flight beats; no valid_o pulse for them.
- Valid chain: v1<=valid_i, v2<=v1, valid_o<=v2. Latency exactly 3 cycles.
- Full throughput: back-to-back valid_i produce back-to-back valid_o.
- Data registers load only when their stage valid is high. result_o holds its last value while valid_o=0.
- Stage 1 (normalise):
  - If product_i[47]=1: man=product[47:24], guard=product[23], sticky=|product[22:0], exp=exp_sum_i+1.
  - Otherwise: man=product[46:23], guard=product[22], sticky=|product[21:0], exp=exp_sum_i.
  - Sign and special flags are registered alongside.
- Stage 2 (round RNE):
  - inc = guard & (sticky | man[0]).
  - man_r = man+inc, computed 25 bits wide.
  - If man_r[24]=1 (carry to 2.0): man_r=24'h800000, exp+1.
  - inexact = guard|sticky.
- Stage 3 (exceptions and pack), priority order:
  1. nan → 32'h7FC00000 (sign ignored).
  2. inf → {sign,8'hFF,23'h0}.
  3. zero → {sign,31'h0}.
  4. exp>=255 → {sign,8'hFF,23'h0} (overflow).
  5. exp<=0 → {sign,31'h0} (underflow, flush-to-zero; tininess detected after rounding).
  6. Otherwise → {sign,exp[7:0],man_r[22:0]}.
- Exponent arithmetic is signed EXP_W-bit throughout. Input range -127..381 never wraps.

Optional Feature:
- Macro FP32_MUL_FLAGS_EN.
- When defined, adds output flags_o[3:0] = {invalid, overflow, underflow, inexact}, registered with and valid alongside result_o; reset 4'h0.
  - invalid is set on nan_i.
  - overflow is set by rule 4 and also sets inexact.
  - underflow is set by rule 5 on a nonzero product and also sets inexact.
  - inexact is also set when guard|sticky on a normal result.
  - Specials never assert overflow, underflow or inexact.
- When undefined, flags_o and its logic are absent; result_o behaviour is identical.

Test Plan:
- Normalisation: product_i=48'h400000000000, exp_sum_i=127, sign_i=0 → result_o=32'h3F800000 exactly 3 cycles later. product_i=48'h900000000000, exp=127 → 32'h40100000.
- RNE: product_i=48'h400000C00000, exp=127 → 32'h3F800002 (tie rounds to even, inexact). product_i=48'h400000400000 → 32'h3F800000 (tie stays even, inexact).
- Round carry: product_i=48'h7FFFFFC00000, exp=127 → 32'h40000000.
- Overflow/underflow: product_i=48'h800000000000, exp=254 → 32'h7F800000 (overflow). product_i=48'h400000000000, exp=0, sign=1 → 32'h80000000 (underflow).
- Specials: nan_i=1 → 32'h7FC00000. inf_i=1, sign=1 → 32'hFF800000. zero_i=1 → 32'h00000000. nan_i takes priority when set together with inf_i.
- Throughput and reset: 8 consecutive valid beats → 8 consecutive valid_o with matching results. rst_i pulsed while 2 beats are in flight → valid_o stays 0 and result_o=0 thereafter.
